// File: rtl/bg_pkg.sv
// Animated background types and constants.
// Palettes, cloud start positions and control enums.
package bg_pkg;
  typedef struct packed {
    logic [11:0] sky;
    logic [11:0] ground;
    logic [11:0] cloud;
  } palette_t;

  localparam palette_t DAY_PAL = '{
    sky: 12'h00F, ground: 12'h0F0, cloud: 12'hFFF
  };
  localparam palette_t NIGHT_PAL = '{
    sky: 12'h001, ground: 12'h060, cloud: 12'h888
  };

  localparam int MAX_CLOUDS = 8;
  localparam int CLOUD_X0 [MAX_CLOUDS] = '{
    100, 350, 600, 850, 220, 470, 720, 970
  };
  localparam int CLOUD_Y [MAX_CLOUDS] = '{
    60, 120, 180, 240, 300, 360, 420, 460
  };

  typedef enum logic [1:0] {
    MODE_DAY    = 2'd0,
    MODE_NIGHT  = 2'd1,
    MODE_AUTO   = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_DAY   = 1'b0,
    ST_NIGHT = 1'b1
  } pal_state_e;
endpackage

// File: rtl/vga_pkg.sv
// VGA chain shared constants.
// Active screen geometry used by every drawing stage.
package vga_pkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between drawing stages.
// Receivers read timing only; senders also drive rgb.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in (
    input vcount, hcount, vsync, hsync, vblnk, hblnk
  );
  modport out (
    output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
  );
endinterface

// File: rtl/cloud_pos.sv
// One drifting cloud: position register and hit test.
// Horizontal distance wraps so clouds straddle the screen edge.
module cloud_pos
  import bg_pkg::*;
#(
  parameter int HOR_PIXELS = 1024,
  parameter int CLOUD_W    = 64,
  parameter int CLOUD_H    = 24,
  parameter int SPEED_W    = 4,
  parameter int INIT_X     = 0,
  parameter int Y          = 0,
  parameter bit ODD        = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_step,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic [10:0]        i_hcount,
  input  logic [10:0]        i_vcount,
  output logic               o_hit
);
  logic [10:0] r_x;
  logic [11:0] w_sum;
  logic [10:0] w_next;
  logic [11:0] w_hc;
  logic [11:0] w_dx;
  logic [11:0] w_dy;

  assign w_sum = {1'b0, r_x} + 12'(i_speed) + 12'(ODD);
  assign w_next = (w_sum >= 12'(HOR_PIXELS))
                ? 11'(w_sum - 12'(HOR_PIXELS))
                : w_sum[10:0];

  assign w_hc = {1'b0, i_hcount};
  assign w_dx = (i_hcount < r_x)
              ? w_hc + 12'(HOR_PIXELS) - {1'b0, r_x}
              : w_hc - {1'b0, r_x};
  assign w_dy = {1'b0, i_vcount} - 12'(Y);

  assign o_hit = (w_dx < 12'(CLOUD_W))
              && (i_vcount >= 11'(Y))
              && (w_dy < 12'(CLOUD_H));

  // Advance position once per frame, wrapping at the right edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= 11'(INIT_X);
    end else if (i_step) begin
      r_x <= w_next;
    end
  end
endmodule

// File: rtl/draw_bg_anim.sv
// Animated background: sky, ground, edge markers, drifting clouds.
// Two-stage pipeline with a day/night palette FSM.
module draw_bg_anim
  import bg_pkg::*;
#(
  parameter int HOR_PIXELS   = vga_pkg::HOR_PIXELS,
  parameter int VER_PIXELS   = vga_pkg::VER_PIXELS,
  parameter int GROUND_Y     = 500,
  parameter int N_CLOUDS     = 4,
  parameter int CLOUD_W      = 64,
  parameter int CLOUD_H      = 24,
  parameter int SPEED_W      = 4,
  parameter int CYCLE_FRAMES = 600
) (
  input  logic               clk,
  input  logic               rst,
  vga_if.in                  vga_in,
  vga_if.out                 vga_out,
  input  logic               scroll_en,
  input  logic [SPEED_W-1:0] speed,
  input  logic [1:0]         mode,
  output logic               night
);
  localparam int CNT_W = $clog2(CYCLE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_FRAMES - 1);

  logic                r_vblnk_prev;
  logic                w_frame_edge;
  logic                w_step;
  logic [N_CLOUDS-1:0] w_hit;
  mode_e               w_mode;
  pal_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;

  logic [N_CLOUDS-1:0] r1_hit;
  logic                r1_blank;
  logic                r1_top;
  logic                r1_bot;
  logic                r1_left;
  logic                r1_right;
  logic                r1_ground;
  logic [10:0]         r1_vc;
  logic [10:0]         r1_hc;
  logic                r1_vs;
  logic                r1_hs;
  logic                r1_vb;
  logic                r1_hb;

  palette_t            w_pal;
  logic [11:0]         w_rgb;

  assign w_frame_edge = vga_in.vblnk & ~r_vblnk_prev;
  assign w_step       = w_frame_edge & scroll_en;
  assign w_mode       = mode_e'(mode);
  assign night        = (r_state == ST_NIGHT);

  for (genvar g = 0; g < N_CLOUDS; g++) begin : g_cloud
    cloud_pos #(
      .HOR_PIXELS(HOR_PIXELS),
      .CLOUD_W   (CLOUD_W),
      .CLOUD_H   (CLOUD_H),
      .SPEED_W   (SPEED_W),
      .INIT_X    (CLOUD_X0[g]),
      .Y         (CLOUD_Y[g]),
      .ODD       (1'((g % 2)))
    ) u_cloud (
      .clk     (clk),
      .rst     (rst),
      .i_step  (w_step),
      .i_speed (speed),
      .i_hcount(vga_in.hcount),
      .i_vcount(vga_in.vcount),
      .o_hit   (w_hit[g])
    );
  end

  // Palette FSM: forced modes apply at the frame edge only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_DAY;
      r_cnt   <= '0;
    end else begin
      unique case (w_mode)
        MODE_DAY: begin
          r_cnt <= '0;
          if (w_frame_edge) r_state <= ST_DAY;
        end
        MODE_NIGHT: begin
          r_cnt <= '0;
          if (w_frame_edge) r_state <= ST_NIGHT;
        end
        MODE_AUTO: begin
          if (w_frame_edge) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= (r_state == ST_DAY)
                       ? ST_NIGHT : ST_DAY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        MODE_FREEZE: begin
        end
      endcase
    end
  end

  // Stage 1: hit vector, region flags and timing capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_prev <= 1'b0;
      r1_hit       <= '0;
      r1_blank     <= 1'b1;
      r1_top       <= 1'b0;
      r1_bot       <= 1'b0;
      r1_left      <= 1'b0;
      r1_right     <= 1'b0;
      r1_ground    <= 1'b0;
      r1_vc        <= '0;
      r1_hc        <= '0;
      r1_vs        <= 1'b0;
      r1_hs        <= 1'b0;
      r1_vb        <= 1'b0;
      r1_hb        <= 1'b0;
    end else begin
      r_vblnk_prev <= vga_in.vblnk;
      r1_hit       <= w_hit;
      r1_blank     <= vga_in.vblnk | vga_in.hblnk;
      r1_top       <= (vga_in.vcount == 11'd0);
      r1_bot       <= (vga_in.vcount == 11'(VER_PIXELS - 1));
      r1_left      <= (vga_in.hcount == 11'd0);
      r1_right     <= (vga_in.hcount == 11'(HOR_PIXELS - 1));
      r1_ground    <= (vga_in.vcount > 11'(GROUND_Y));
      r1_vc        <= vga_in.vcount;
      r1_hc        <= vga_in.hcount;
      r1_vs        <= vga_in.vsync;
      r1_hs        <= vga_in.hsync;
      r1_vb        <= vga_in.vblnk;
      r1_hb        <= vga_in.hblnk;
    end
  end

  // Priority colour mux for stage 2
  always_comb begin
    w_pal = (r_state == ST_NIGHT) ? NIGHT_PAL : DAY_PAL;
    w_rgb = w_pal.sky;
    if (r1_blank)       w_rgb = 12'h000;
    else if (r1_top)    w_rgb = 12'hFF0;
    else if (r1_bot)    w_rgb = 12'hF00;
    else if (r1_left)   w_rgb = 12'h0F0;
    else if (r1_right)  w_rgb = 12'h00F;
    else if (r1_ground) w_rgb = w_pal.ground;
    else if (|r1_hit)   w_rgb = w_pal.cloud;
  end

  // Stage 2: registered rgb and re-delayed timing
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.hcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.hsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= r1_vc;
      vga_out.hcount <= r1_hc;
      vga_out.vsync  <= r1_vs;
      vga_out.hsync  <= r1_hs;
      vga_out.vblnk  <= r1_vb;
      vga_out.hblnk  <= r1_hb;
      vga_out.rgb    <= w_rgb;
    end
  end
endmodule
